sine_sequencer: RTL and testbench

Phase sequencer that drives the quarter-wave sine sample memory (128 entries, 1-cycle registered read, quadrants PEAK/FALL/TROUGH/RISE). Holds a 9-bit phase accumulator split into quadrant (`read_state`) and table index (`read_address`), and advances it by a programmable step at a divided sample rate. Emits `sample_valid` aligned to the memory's registered output, plus a once-per-period `wrap` pulse. It sits between the top-level tone/frequency control and the sample memory, feeding the downstream DAC/PWM stage.

---
 rtl/sine_sequencer.sv | 88 ++++++++
 tb/tb_sine_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sine_sequencer.sv
// Phase sequencer for the quarter-wave sine memory: 9-bit phase accumulator
// advanced by a programmable step at a divided rate, step latched per period.
module sine_sequencer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_sync,
    input  logic [6:0] i_step,
    output logic [6:0] o_read_address,
    output logic [1:0] o_read_state,
    output logic       o_sample_valid,
    output logic       o_wrap
);

    localparam int unsigned    CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);

    logic [8:0]    r_phase;
    logic [CW-1:0] r_tick;
    logic [6:0]    r_step_active;
    logic          r_load_pending;
    logic          r_upd;
    logic          r_sample_valid;
    logic          r_wrap;

    logic          w_advance;
    logic [6:0]    w_eff_step;
    logic [9:0]    w_sum;

    always_comb begin
        w_advance  = 1'b0;
        w_eff_step = r_step_active;
        w_sum      = '0;
        w_advance  = i_enable && (r_tick == TICK_LAST);
        if (r_load_pending) begin
            w_eff_step = i_step;
        end
        w_sum = {1'b0, r_phase} + {3'b000, w_eff_step};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase        <= '0;
            r_tick         <= '0;
            r_step_active  <= '0;
            r_load_pending <= 1'b1;
            r_upd          <= 1'b0;
            r_sample_valid <= 1'b0;
            r_wrap         <= 1'b0;
        end else begin
            // sample_valid trails every address update by exactly one edge,
            // matching the memory's registered read.
            r_sample_valid <= r_upd;
            if (i_sync) begin
                r_phase        <= '0;
                r_tick         <= '0;
                r_load_pending <= 1'b1;
                r_wrap         <= 1'b0;
                r_upd          <= 1'b1;
            end else if (w_advance) begin
                r_phase <= w_sum[8:0];
                r_tick  <= '0;
                r_wrap  <= w_sum[9];
                r_upd   <= 1'b1;
                if (r_load_pending) begin
                    r_step_active <= i_step;
                end
                // A carry re-arms the step load so frequency changes land on
                // period boundaries only.
                r_load_pending <= w_sum[9];
            end else begin
                r_wrap <= 1'b0;
                r_upd  <= 1'b0;
                if (i_enable) begin
                    r_tick <= r_tick + CW'(1);
                end
            end
        end
    end

    assign o_read_address = r_phase[6:0];
    assign o_read_state   = r_phase[8:7];
    assign o_sample_valid = r_sample_valid;
    assign o_wrap         = r_wrap;

endmodule

// File: tb/tb_sine_sequencer.sv
// Directed self-checking bench for sine_sequencer: one instance at TICK_DIV=1,
// one at TICK_DIV=3, expectations hand-computed from the phase arithmetic.
module tb_sine_sequencer;

    logic       clk;
    logic       rst_n;
    logic       a_enable, a_sync;
    logic [6:0] a_step;
    logic [6:0] a_addr;
    logic [1:0] a_state;
    logic       a_sv, a_wrap;
    logic       b_enable, b_sync;
    logic [6:0] b_step;
    logic [6:0] b_addr;
    logic [1:0] b_state;
    logic       b_sv, b_wrap;

    int checks;
    int errors;

    sine_sequencer #(.TICK_DIV(1)) u_dut_a (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (a_enable),
        .i_sync         (a_sync),
        .i_step         (a_step),
        .o_read_address (a_addr),
        .o_read_state   (a_state),
        .o_sample_valid (a_sv),
        .o_wrap         (a_wrap)
    );

    sine_sequencer #(.TICK_DIV(3)) u_dut_b (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (b_enable),
        .i_sync         (b_sync),
        .i_step         (b_step),
        .o_read_address (b_addr),
        .o_read_state   (b_state),
        .o_sample_valid (b_sv),
        .o_wrap         (b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int phase_a();
        return int'({a_state, a_addr});
    endfunction

    function automatic int phase_b();
        return int'({b_state, b_addr});
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        a_enable = 1'b0;
        a_sync   = 1'b0;
        a_step   = 7'd0;
        b_enable = 1'b0;
        b_sync   = 1'b0;
        b_step   = 7'd0;

        tick();
        check("rst_phase", phase_a(), 0);
        check("rst_sv", int'(a_sv), 0);
        check("rst_wrap", int'(a_wrap), 0);
        check("rst_phase_b", phase_b(), 0);

        // Full period with step 1
        rst_n    = 1'b1;
        a_enable = 1'b1;
        a_step   = 7'd1;
        for (int k = 1; k <= 512; k++) begin
            tick();
            check("ramp_phase", phase_a(), k % 512);
            check("ramp_sv", int'(a_sv), (k >= 2) ? 1 : 0);
            check("ramp_wrap", int'(a_wrap), (k == 512) ? 1 : 0);
        end

        // Step change mid-period takes effect only after wrap
        a_step = 7'd4;
        for (int j = 1; j <= 25; j++) begin
            tick();
            check("s4_phase", phase_a(), 4 * j);
        end
        a_step = 7'd16;
        for (int j = 1; j <= 103; j++) begin
            tick();
            check("latch_phase", phase_a(), (100 + 4 * j) % 512);
            check("latch_wrap", int'(a_wrap), (j == 103) ? 1 : 0);
        end
        tick();
        check("s16_first", phase_a(), 16);
        check("s16_wrap", int'(a_wrap), 0);
        tick();
        check("s16_second", phase_a(), 32);

        // Sync coinciding with an advance, then step 127 through the wrap
        a_sync = 1'b1;
        a_step = 7'd127;
        tick();
        a_sync = 1'b0;
        check("sync_phase", phase_a(), 0);
        check("sync_nowrap", int'(a_wrap), 0);
        for (int j = 1; j <= 5; j++) begin
            tick();
            check("odd_state", int'(a_state), ((127 * j) % 512) >> 7);
            check("odd_addr", int'(a_addr), ((127 * j) % 512) & 127);
            check("odd_wrap", int'(a_wrap), (j == 5) ? 1 : 0);
        end
        check("odd_final", phase_a(), 123);

        // Reach phase 200, then hold with enable low
        a_sync = 1'b1;
        a_step = 7'd8;
        tick();
        a_sync = 1'b0;
        for (int j = 1; j <= 25; j++) tick();
        check("hold_start", phase_a(), 200);
        a_enable = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            check("hold_phase", phase_a(), 200);
            check("hold_sv", int'(a_sv), (j == 1) ? 1 : 0);
        end
        a_sync = 1'b1;
        tick();
        a_sync = 1'b0;
        check("hsync_phase", phase_a(), 0);
        check("hsync_wrap", int'(a_wrap), 0);
        check("hsync_sv0", int'(a_sv), 0);
        tick();
        check("hsync_sv1", int'(a_sv), 1);
        check("hsync_hold", phase_a(), 0);
        tick();
        check("hsync_sv2", int'(a_sv), 0);

        // Async reset between edges at phase 300
        a_enable = 1'b1;
        a_step   = 7'd20;
        for (int j = 1; j <= 15; j++) tick();
        check("pre_rst_phase", phase_a(), 300);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_phase", phase_a(), 0);
        check("arst_sv", int'(a_sv), 0);
        check("arst_wrap", int'(a_wrap), 0);
        a_step = 7'd5;
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_p1", phase_a(), 5);
        check("post_rst_sv1", int'(a_sv), 0);
        tick();
        check("post_rst_p2", phase_a(), 10);
        check("post_rst_sv2", int'(a_sv), 1);

        // Divided rate on the TICK_DIV=3 instance
        check("div_start", phase_b(), 0);
        b_enable = 1'b1;
        b_step   = 7'd1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("div_phase", phase_b(), k / 3);
            check("div_sv", int'(b_sv), (k >= 4 && (k % 3) == 1) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
